// File: rtl/conv_multadd_sched.sv
// Window scheduler for the dual-product multiply-add unit: issues operand pairs, tags them
// through the unit's pipeline and accumulates one dot-product per window.
// Optional build macro: MULTADD_SAT_EN (saturating accumulation instead of wrap-around).
module conv_multadd_sched #(
    parameter int unsigned ASIZE  = 8,
    parameter int unsigned BSIZE  = 8,
    parameter int unsigned MA_LAT = 3,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned CNT_W  = 8,
    localparam int unsigned PSIZE = ASIZE + BSIZE + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ASIZE-1:0] in_a0,
    input  logic [ASIZE-1:0] in_a1,
    input  logic [BSIZE-1:0] in_b0,
    input  logic [BSIZE-1:0] in_b1,
    input  logic             in_last,
    output logic             ma_ce,
    output logic             ma_rst,
    output logic [ASIZE-1:0] ma_a0,
    output logic [ASIZE-1:0] ma_a1,
    output logic [BSIZE-1:0] ma_b0,
    output logic [BSIZE-1:0] ma_b1,
    input  logic [PSIZE-1:0] ma_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDrain,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [MA_LAT-1:0] tag_v_q, tag_v_d;
    logic [MA_LAT-1:0] tag_l_q, tag_l_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  out_acc_q, out_acc_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              ma_ce_q, ma_ce_d;

    logic              hs;
    logic              tag_v_out;
    logic              tag_l_out;
    logic [ACC_W:0]    sum_w;
    logic [ACC_W-1:0]  acc_sum;

    assign hs        = in_valid & in_ready_q;
    assign tag_v_out = tag_v_q[MA_LAT-1] & ma_ce_q;
    assign tag_l_out = tag_l_q[MA_LAT-1];

    assign ma_a0 = hs ? in_a0 : '0;
    assign ma_a1 = hs ? in_a1 : '0;
    assign ma_b0 = hs ? in_b0 : '0;
    assign ma_b1 = hs ? in_b1 : '0;

    assign ma_rst    = rst;
    assign ma_ce     = ma_ce_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_cnt   = out_cnt_q;

    // One spare bit catches the carry for the saturating build.
    always_comb begin
        sum_w = {1'b0, acc_q} + (ACC_W + 1)'(ma_p);
`ifdef MULTADD_SAT_EN
        acc_sum = sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];
`else
        acc_sum = sum_w[ACC_W-1:0];
`endif
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_acc_d   = out_acc_q;
        out_cnt_d   = out_cnt_q;
        out_valid_d = out_valid_q;
        tag_v_d     = tag_v_q;
        tag_l_d     = tag_l_q;

        // Tags move only while the multiply-add unit advances, keeping them aligned with ma_p.
        if (ma_ce_q) begin
            tag_v_d[0] = hs;
            tag_l_d[0] = hs & in_last;
            for (int i = 1; i < MA_LAT; i++) begin
                tag_v_d[i] = tag_v_q[i-1];
                tag_l_d[i] = tag_l_q[i-1];
            end
        end

        if (tag_v_out) begin
            acc_d = acc_sum;
        end

        unique case (state_q)
            StIdle: begin
                if (hs) begin
                    cnt_d   = CNT_W'(1);
                    state_d = in_last ? StDrain : StAccum;
                end
            end
            StAccum: begin
                if (hs) begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                    if (in_last) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (tag_v_out && tag_l_out) begin
                    out_acc_d   = acc_sum;
                    out_cnt_d   = cnt_q;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (abort) begin
            state_d     = StIdle;
            acc_d       = '0;
            cnt_d       = '0;
            tag_v_d     = '0;
            tag_l_d     = '0;
            out_valid_d = 1'b0;
        end

        in_ready_d = (state_d == StIdle) || (state_d == StAccum);
        ma_ce_d    = (state_d != StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            tag_v_q     <= '0;
            tag_l_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_acc_q   <= '0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            ma_ce_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            tag_v_q     <= tag_v_d;
            tag_l_q     <= tag_l_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_acc_q   <= out_acc_d;
            out_cnt_q   <= out_cnt_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            ma_ce_q     <= ma_ce_d;
        end
    end

endmodule

// File: tb/tb_conv_multadd_sched.sv
// Directed bench for conv_multadd_sched with a behavioural multiply-add pipeline attached.
// Uses ACC_W=17 so the wrap/saturate window is reachable; honours MULTADD_SAT_EN.
module tb_conv_multadd_sched;

    localparam int unsigned ASIZE  = 8;
    localparam int unsigned BSIZE  = 8;
    localparam int unsigned MA_LAT = 3;
    localparam int unsigned ACC_W  = 17;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned PSIZE  = ASIZE + BSIZE + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             abort = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [ASIZE-1:0] in_a0 = '0;
    logic [ASIZE-1:0] in_a1 = '0;
    logic [BSIZE-1:0] in_b0 = '0;
    logic [BSIZE-1:0] in_b1 = '0;
    logic             in_last = 1'b0;
    logic             ma_ce;
    logic             ma_rst;
    logic [ASIZE-1:0] ma_a0;
    logic [ASIZE-1:0] ma_a1;
    logic [BSIZE-1:0] ma_b0;
    logic [BSIZE-1:0] ma_b1;
    logic [PSIZE-1:0] ma_p;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    conv_multadd_sched #(
        .ASIZE (ASIZE),
        .BSIZE (BSIZE),
        .MA_LAT(MA_LAT),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .abort    (abort),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a0    (in_a0),
        .in_a1    (in_a1),
        .in_b0    (in_b0),
        .in_b1    (in_b1),
        .in_last  (in_last),
        .ma_ce    (ma_ce),
        .ma_rst   (ma_rst),
        .ma_a0    (ma_a0),
        .ma_a1    (ma_a1),
        .ma_b0    (ma_b0),
        .ma_b1    (ma_b1),
        .ma_p     (ma_p),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_acc  (out_acc),
        .out_cnt  (out_cnt)
    );

    // Multiply-add unit model: p = a0*b0 + a1*b1, MA_LAT register stages gated by ce.
    logic [PSIZE-1:0] mp_q [MA_LAT];
    always_ff @(posedge clk or posedge ma_rst) begin
        if (ma_rst) begin
            for (int i = 0; i < MA_LAT; i++) mp_q[i] <= '0;
        end else if (ma_ce) begin
            mp_q[0] <= PSIZE'(ma_a0) * PSIZE'(ma_b0) + PSIZE'(ma_a1) * PSIZE'(ma_b1);
            for (int i = 1; i < MA_LAT; i++) mp_q[i] <= mp_q[i-1];
        end
    end
    assign ma_p = mp_q[MA_LAT-1];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input logic [7:0] a0, input logic [7:0] b0, input logic [7:0] a1,
                             input logic [7:0] b1, input logic last);
        in_valid = 1'b1;
        in_a0    = a0;
        in_b0    = b0;
        in_a1    = a1;
        in_b1    = b1;
        in_last  = last;
        #1;
        check_eq("issue_a0", 32'(ma_a0), 32'(a0));
        check_eq("issue_b1", 32'(ma_b1), 32'(b1));
        tick();
        in_valid = 1'b0;
        in_a0    = '0;
        in_b0    = '0;
        in_a1    = '0;
        in_b1    = '0;
        in_last  = 1'b0;
    endtask

    // Called right after the last-pair handshake edge; returns edges until out_valid.
    task automatic wait_result(input string tag, output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 50) begin
            tick();
            cycles++;
        end
        if (!out_valid) check_eq({tag, "_timeout"}, 32'(out_valid), 32'd1);
    endtask

    int  cyc;
    bit  seen;
    logic [ACC_W-1:0] held_acc;
    logic [ACC_W-1:0] exp_big;

    initial begin
        // Reset state
        tick();
        tick();
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_ma_ce", 32'(ma_ce), 32'd1);
        check_eq("rst_ma_rst", 32'(ma_rst), 32'd1);
        check_eq("rst_out_acc", 32'(out_acc), 32'd0);
        check_eq("rst_out_cnt", 32'(out_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // Three pairs of 1*2+3*4 = 14
        send_pair(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
        send_pair(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
        send_pair(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
        check_eq("drain_in_ready", 32'(in_ready), 32'd0);
        wait_result("w3", cyc);
        check_eq("w3_latency", 32'(cyc + 1), 32'(MA_LAT + 1));
        check_eq("w3_acc", 32'(out_acc), 32'd42);
        check_eq("w3_cnt", 32'(out_cnt), 32'd3);
        check_eq("done_ma_ce", 32'(ma_ce), 32'd0);
        tick();
        check_eq("w3_valid_1cyc", 32'(out_valid), 32'd0);
        check_eq("w3_back_idle", 32'(in_ready), 32'd1);

        // Single-pair window of maximum operands
        send_pair(8'd255, 8'd255, 8'd255, 8'd255, 1'b1);
        wait_result("w1", cyc);
        check_eq("w1_acc", 32'(out_acc), 32'd130050);
        check_eq("w1_cnt", 32'(out_cnt), 32'd1);
        tick();

        // Window with gaps in in_valid
        send_pair(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
        in_a0 = 8'd9;
        #1;
        check_eq("gap_ma_a0_zero", 32'(ma_a0), 32'd0);
        tick();
        tick();
        send_pair(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
        check_eq("gap_in_ready_drain", 32'(in_ready), 32'd0);
        wait_result("wg", cyc);
        check_eq("wg_acc", 32'(out_acc), 32'd28);
        check_eq("wg_cnt", 32'(out_cnt), 32'd2);
        check_eq("wg_in_ready_done", 32'(in_ready), 32'd0);
        tick();

        // Back-pressure on the result port
        out_ready = 1'b0;
        send_pair(8'd2, 8'd5, 8'd1, 8'd1, 1'b0);
        send_pair(8'd3, 8'd3, 8'd0, 8'd7, 1'b1);
        wait_result("wb", cyc);
        held_acc = out_acc;
        check_eq("wb_acc", 32'(out_acc), 32'd20);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_acc", 32'(out_acc), 32'(held_acc));
            check_eq("hold_ma_ce", 32'(ma_ce), 32'd0);
            check_eq("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check_eq("release_valid", 32'(out_valid), 32'd0);
        check_eq("release_idle", 32'(in_ready), 32'd1);

        // Abort during drain discards the window
        send_pair(8'd10, 8'd10, 8'd10, 8'd10, 1'b0);
        send_pair(8'd10, 8'd10, 8'd10, 8'd10, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        check_eq("abort_no_valid", 32'(seen), 32'd0);
        check_eq("abort_idle", 32'(in_ready), 32'd1);
        send_pair(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
        send_pair(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
        wait_result("wa", cyc);
        check_eq("post_abort_acc", 32'(out_acc), 32'd28);
        check_eq("post_abort_cnt", 32'(out_cnt), 32'd2);
        tick();

        // Reset in mid-window loses the window without a spurious result
        send_pair(8'd7, 8'd7, 8'd7, 8'd7, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        check_eq("midrst_no_valid", 32'(seen), 32'd0);
        check_eq("midrst_idle", 32'(in_ready), 32'd1);

        // Accumulator overflow with 3 x 130050 in a 17-bit accumulator
`ifdef MULTADD_SAT_EN
        exp_big = 17'd131071;
`else
        exp_big = 17'((3 * 130050) % 131072);
`endif
        send_pair(8'd255, 8'd255, 8'd255, 8'd255, 1'b0);
        send_pair(8'd255, 8'd255, 8'd255, 8'd255, 1'b0);
        send_pair(8'd255, 8'd255, 8'd255, 8'd255, 1'b1);
        wait_result("wo", cyc);
        check_eq("ovf_acc", 32'(out_acc), 32'(exp_big));
        check_eq("ovf_cnt", 32'(out_cnt), 32'd3);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
